if_fetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the program counter and owns the handshake with a variable-latency instruction memory. It issues one word-aligned fetch at a time, advances the PC by 4 per accepted word, and holds returned instructions in an output register plus a one-entry skid buffer when decode stalls. Taken branches redirect it, and it squashes any stale in-flight or buffered words. It sits between the instruction memory port and the IF/ID pipeline register.

---
 rtl/if_fetch_ctrl.sv | 130 +++++++++++++
 tb/tb_if_fetch_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - instruction-fetch PC sequencer with one-outstanding memory handshake
// Output register plus one-entry skid absorb decode stalls; taken branches squash stale words.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target_addr,
  output logic        mem_ce,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] redirect_pc;
  logic        skid_valid;
  logic [31:0] skid_inst;
  logic [31:0] skid_pc;

  logic [31:0] target;
  logic        consume;
  logic        out_free;

  assign target   = {branch_target_addr[31:2], 2'b00};
  assign consume  = inst_valid && !stall;
  assign out_free = !inst_valid || !stall;

  // S_DROP keeps the stale request on the bus until its ack arrives.
  assign mem_ce   = (state == S_REQ) || (state == S_DROP);
  assign mem_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      redirect_pc <= RESET_PC;
      inst_valid  <= 1'b0;
      inst        <= 32'h0;
      inst_pc     <= 32'h0;
      skid_valid  <= 1'b0;
      skid_inst   <= 32'h0;
      skid_pc     <= 32'h0;
    end else begin
      if (consume) begin
        inst_valid <= 1'b0;
      end

      if (branch_flag) begin
        // A word consumed in the branch cycle is the delay slot; nothing refills it.
        inst_valid <= 1'b0;
        skid_valid <= 1'b0;
        case (state)
          S_IDLE: begin
            pc    <= target;
            state <= S_REQ;
          end
          S_REQ: begin
            if (mem_ack) begin
              pc <= target;
            end else begin
              redirect_pc <= target;
              state       <= S_DROP;
            end
          end
          S_HOLD: begin
            pc    <= target;
            state <= S_REQ;
          end
          default: begin
            if (mem_ack) begin
              pc    <= target;
              state <= S_REQ;
            end else begin
              redirect_pc <= target;
            end
          end
        endcase
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_REQ;
          end
          S_REQ: begin
            if (mem_ack) begin
              pc <= pc + 32'd4;
              if (out_free) begin
                inst_valid <= 1'b1;
                inst       <= mem_data;
                inst_pc    <= pc;
              end else begin
                skid_valid <= 1'b1;
                skid_inst  <= mem_data;
                skid_pc    <= pc;
                state      <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (!stall) begin
              inst_valid <= skid_valid;
              inst       <= skid_inst;
              inst_pc    <= skid_pc;
              skid_valid <= 1'b0;
              state      <= S_REQ;
            end
          end
          default: begin
            if (mem_ack) begin
              pc    <= redirect_pc;
              state <= S_REQ;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - self-checking bench for if_fetch_ctrl
// Vector tables for directed corners, then randomized runs against a stream-level PC model.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, branch_flag, mem_ack;
  logic [31:0] branch_target_addr;
  logic        mem_ce, inst_valid;
  logic [31:0] mem_addr, mem_data, inst, inst_pc;

  logic        rst2, ack2, ce2, iv2;
  logic        stall2 = 1'b0;
  logic        br2 = 1'b0;
  logic [31:0] tgt2 = 32'h0;
  logic [31:0] addr2, data2, inst2, pc2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign mem_data = hash(mem_addr);
  assign data2    = hash(addr2);

  if_fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
    .branch_target_addr(branch_target_addr), .mem_ce(mem_ce), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc)
  );

  if_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst2), .stall(stall2), .branch_flag(br2),
    .branch_target_addr(tgt2), .mem_ce(ce2), .mem_addr(addr2),
    .mem_ack(ack2), .mem_data(data2), .inst_valid(iv2), .inst(inst2),
    .inst_pc(pc2)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic        e_ce;
    logic [31:0] e_addr;
    logic        e_iv;
    logic        chk_pc;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tab1[$];
  vec_t tab2[$];

  function automatic vec_t mk(logic r, logic s, logic b, logic [31:0] t, logic a,
                              logic ce, logic [31:0] ad, logic iv, logic cp, logic [31:0] p);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.ack = a;
    v.e_ce = ce; v.e_addr = ad; v.e_iv = iv; v.chk_pc = cp; v.e_pc = p;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h, want %h", name, idx, act, exp);
    end
  endtask

  // Row: drive inputs, compare the registered outputs of this cycle, then clock.
  task automatic run_row(input int sel, input int idx, input vec_t v);
    logic        ce, iv;
    logic [31:0] ad, ins, ipc;
    if (sel == 0) begin
      rst = v.rst; stall = v.stall; branch_flag = v.br;
      branch_target_addr = v.tgt; mem_ack = v.ack;
      ce = mem_ce; ad = mem_addr; iv = inst_valid; ins = inst; ipc = inst_pc;
    end else begin
      rst2 = v.rst; ack2 = v.ack;
      ce = ce2; ad = addr2; iv = iv2; ins = inst2; ipc = pc2;
    end
    chk(sel == 0 ? "t1_mem_ce" : "t2_mem_ce", idx, {31'h0, ce}, {31'h0, v.e_ce});
    chk(sel == 0 ? "t1_mem_addr" : "t2_mem_addr", idx, ad, v.e_addr);
    chk(sel == 0 ? "t1_inst_valid" : "t2_inst_valid", idx, {31'h0, iv}, {31'h0, v.e_iv});
    if (v.chk_pc) begin
      chk(sel == 0 ? "t1_inst_pc" : "t2_inst_pc", idx, ipc, v.e_pc);
      chk(sel == 0 ? "t1_inst" : "t2_inst", idx, ins, v.e_iv ? hash(v.e_pc) : 32'h0);
    end
    step();
  endtask

  task automatic reset_dut1();
    rst = 1'b0; stall = 1'b0; branch_flag = 1'b0; mem_ack = 1'b0;
    branch_target_addr = 32'h0;
    step(); step();
    rst = 1'b1;
  endtask

  // Stream-level model: IF/ID must see consecutive word addresses from the reset PC,
  // with inst == memory contents, restarting at the target after any consumed delay slot.
  task automatic run_rand(input string tag, input int n, input int lat, input int ack_pct,
                          input int stall_pct, input int br_pct, output int consumed);
    logic [31:0] exp_pc, prev_addr, t;
    logic        prev_ce, prev_ack, a, s, b;
    int          wcnt;
    reset_dut1();
    exp_pc = 32'h0; prev_ce = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0;
    wcnt = 0; consumed = 0;
    for (int i = 0; i < n; i++) begin
      if (lat >= 0) begin
        if (mem_ce) begin
          a = (wcnt == lat);
          wcnt = a ? 0 : wcnt + 1;
        end else begin
          a = 1'b0;
          wcnt = 0;
        end
      end else begin
        a = ($urandom_range(0, 99) < ack_pct);
      end
      s = ($urandom_range(0, 99) < stall_pct);
      b = ($urandom_range(0, 99) < br_pct);
      t = $urandom;
      mem_ack = a; stall = s; branch_flag = b; branch_target_addr = t;

      if (prev_ce && !prev_ack) begin
        chk({tag, "_ce_hold"}, i, {31'h0, mem_ce}, 32'h1);
        chk({tag, "_addr_hold"}, i, mem_addr, prev_addr);
      end
      if (inst_valid && !s) begin
        chk({tag, "_pc_order"}, i, inst_pc, exp_pc);
        chk({tag, "_inst_data"}, i, inst, hash(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (b) exp_pc = {t[31:2], 2'b00};
      prev_ce = mem_ce; prev_ack = a; prev_addr = mem_addr;
      step();
    end
    branch_flag = 1'b0; stall = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    int cnt;
    rst2 = 1'b0; ack2 = 1'b0;
    reset_dut1();
    rst = 1'b0;

    tab1.push_back(mk(0,0,0,32'h0,  1, 0,32'h0,  0,1,32'h0));
    tab1.push_back(mk(1,0,0,32'h0,  1, 0,32'h0,  0,0,32'h0));
    tab1.push_back(mk(1,0,0,32'h0,  1, 1,32'h0,  0,0,32'h0));
    tab1.push_back(mk(1,0,0,32'h0,  1, 1,32'h4,  1,1,32'h0));
    tab1.push_back(mk(1,0,0,32'h0,  1, 1,32'h8,  1,1,32'h4));
    tab1.push_back(mk(1,1,0,32'h0,  1, 1,32'hC,  1,1,32'h8));
    for (int k = 0; k < 4; k++)
      tab1.push_back(mk(1,1,0,32'h0,1, 0,32'h10, 1,1,32'h8));
    tab1.push_back(mk(1,0,0,32'h0,  1, 0,32'h10, 1,1,32'h8));
    tab1.push_back(mk(1,0,0,32'h0,  0, 1,32'h10, 1,1,32'hC));
    tab1.push_back(mk(1,0,0,32'h0,  0, 1,32'h10, 0,0,32'h0));
    tab1.push_back(mk(1,0,1,32'h100,1, 1,32'h10, 0,0,32'h0));
    tab1.push_back(mk(1,0,0,32'h0,  0, 1,32'h100,0,0,32'h0));
    tab1.push_back(mk(1,0,1,32'h203,0, 1,32'h100,0,0,32'h0));
    tab1.push_back(mk(1,0,1,32'h300,0, 1,32'h100,0,0,32'h0));
    tab1.push_back(mk(1,0,0,32'h0,  1, 1,32'h100,0,0,32'h0));
    tab1.push_back(mk(1,0,0,32'h0,  1, 1,32'h300,0,0,32'h0));
    tab1.push_back(mk(1,1,0,32'h0,  1, 1,32'h304,1,1,32'h300));
    tab1.push_back(mk(1,1,1,32'h41, 1, 0,32'h308,1,1,32'h300));
    tab1.push_back(mk(1,0,0,32'h0,  1, 1,32'h40, 0,0,32'h0));
    tab1.push_back(mk(1,0,1,32'h80, 1, 1,32'h44, 1,1,32'h40));
    tab1.push_back(mk(1,0,0,32'h0,  1, 1,32'h80, 0,0,32'h0));
    tab1.push_back(mk(1,0,0,32'h0,  0, 1,32'h84, 1,1,32'h80));
    foreach (tab1[i]) run_row(0, i, tab1[i]);

    rst2 = 1'b0; step(); step();
    tab2.push_back(mk(0,0,0,32'h0,1, 0,32'hFFFF_FFF8,0,1,32'h0));
    tab2.push_back(mk(1,0,0,32'h0,1, 0,32'hFFFF_FFF8,0,0,32'h0));
    tab2.push_back(mk(1,0,0,32'h0,1, 1,32'hFFFF_FFF8,0,0,32'h0));
    tab2.push_back(mk(1,0,0,32'h0,1, 1,32'hFFFF_FFFC,1,1,32'hFFFF_FFF8));
    tab2.push_back(mk(1,0,0,32'h0,1, 1,32'h0000_0000,1,1,32'hFFFF_FFFC));
    tab2.push_back(mk(1,0,0,32'h0,0, 1,32'h0000_0004,1,1,32'h0000_0000));
    tab2.push_back(mk(1,0,0,32'h0,0, 1,32'h0000_0004,0,0,32'h0));
    tab2.push_back(mk(0,0,0,32'h0,0, 1,32'h0000_0004,0,0,32'h0));
    tab2.push_back(mk(1,0,0,32'h0,0, 0,32'hFFFF_FFF8,0,1,32'h0));
    tab2.push_back(mk(1,0,0,32'h0,1, 1,32'hFFFF_FFF8,0,0,32'h0));
    tab2.push_back(mk(1,0,0,32'h0,1, 1,32'hFFFF_FFFC,1,1,32'hFFFF_FFF8));
    foreach (tab2[i]) run_row(1, i, tab2[i]);

    run_rand("lat3", 300, 2, 0, 0, 0, cnt);
    chk("lat3_rate_lo", 0, {31'h0, cnt >= 95}, 32'h1);
    chk("lat3_rate_hi", 0, {31'h0, cnt <= 101}, 32'h1);

    run_rand("zw_stall", 500, 0, 0, 40, 0, cnt);
    chk("zw_stall_progress", 0, {31'h0, cnt >= 100}, 32'h1);

    run_rand("rnd", 4000, -1, 45, 30, 6, cnt);
    chk("rnd_progress", 0, {31'h0, cnt >= 200}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
